// File: rtl/comp_share_arb_pkg.sv
// -----------------------------------------------------------------------------
// comp_share_arb_pkg
// Shared definitions for the comparator-sharing arbiter:
//   - state_t   : arbiter FSM encoding (IDLE / EVAL / RESP)
//   - idw_calc  : width of a requester index, never less than one bit
// -----------------------------------------------------------------------------
package comp_share_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    // Index width for n requesters; a single requester still needs a 1-bit id.
    function automatic int idw_calc(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/comp_share_arb_chk.sv
// -----------------------------------------------------------------------------
// comp_share_arb_chk
// Passive property checker for comp_share_arb; observes the block's ports only.
// Ports: same names as the arbiter's ports, all inputs here.
// -----------------------------------------------------------------------------
module comp_share_arb_chk
    import comp_share_arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input logic                         clk,
    input logic                         rst,
    input logic [NREQ-1:0]              gnt,
    input logic                         rsp_valid,
    input logic                         rsp_ready,
    input logic [idw_calc(NREQ)-1:0]    rsp_id,
    input logic                         gt,
    input logic                         eq,
    input logic                         lt,
    input logic                         busy
);

    // At most one requester is granted at a time.
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
        else $error("chk: gnt not one-hot");

    // A grant lasts exactly one cycle.
    a_gnt_pulse: assert property (@(posedge clk) disable iff (rst) (|gnt) |=> !(|gnt))
        else $error("chk: gnt held longer than one cycle");

    // A valid response carries exactly one relation flag.
    a_flags_onehot: assert property (@(posedge clk) disable iff (rst) rsp_valid |-> $onehot({gt, eq, lt}))
        else $error("chk: relation flags not one-hot while valid");

    // A response can only exist outside IDLE.
    a_valid_busy: assert property (@(posedge clk) disable iff (rst) rsp_valid |-> busy)
        else $error("chk: rsp_valid while not busy");

    // A stalled response stays put.
    a_hold: assert property (@(posedge clk) disable iff (rst)
                             (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_id) && $stable({gt, eq, lt})))
        else $error("chk: response changed under back-pressure");

endmodule

// File: rtl/comp_share_arb_core.sv
// -----------------------------------------------------------------------------
// comp_core
// Purely combinational unsigned magnitude comparator; the single shared
// datapath behind comp_share_arb.
// Ports:
//   a, b   : WIDTH-bit unsigned operands
//   gt     : a >  b
//   eq     : a == b
//   lt     : a <  b
// Exactly one of gt/eq/lt is high for any operand pair.
// -----------------------------------------------------------------------------
module comp_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    // Operands are compared at their native width, so the compare is unsigned.
    always_comb begin
        gt = (a > b);
        eq = (a == b);
        lt = (a < b);
    end

endmodule

// File: rtl/comp_share_arb.sv
// -----------------------------------------------------------------------------
// comp_share_arb
// Shares one unsigned comparator (comp_core) among NREQ requesters. A
// round-robin arbiter picks one requester in IDLE, captures its operands,
// evaluates them in EVAL and presents a tagged gt/eq/lt result in RESP until
// the consumer accepts it.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   req        : per-requester request
//   a_in, b_in : packed operands, requester i in bits [i*WIDTH +: WIDTH]
//   gnt        : one-hot grant, high for the EVAL cycle only
//   rsp_valid  : result available
//   rsp_ready  : consumer accepts the result
//   rsp_id     : index of the requester the result belongs to
//   gt/eq/lt   : relation of captured A to captured B (qualify with rsp_valid)
//   busy       : high whenever the arbiter is not IDLE
// All outputs are registered.
// -----------------------------------------------------------------------------
module comp_share_arb
    import comp_share_arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*WIDTH-1:0]       a_in,
    input  logic [NREQ*WIDTH-1:0]       b_in,
    output logic [NREQ-1:0]             gnt,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [idw_calc(NREQ)-1:0]   rsp_id,
    output logic                        gt,
    output logic                        eq,
    output logic                        lt,
    output logic                        busy
);

    localparam int IDW = idw_calc(NREQ);

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [IDW-1:0]         ptr_r;
    logic [IDW-1:0]         id_r;
    logic [WIDTH-1:0]       a_r;
    logic [WIDTH-1:0]       b_r;
    logic [WIDTH-1:0]       a_arr_s [NREQ];
    logic [WIDTH-1:0]       b_arr_s [NREQ];
    logic [IDW-1:0]         win_id_s;
    logic                   win_found_s;
    logic [NREQ-1:0]        grant_vec_s;
    logic                   grant_en_s;
    logic                   eval_en_s;
    logic                   accept_s;
    logic                   core_gt_s;
    logic                   core_eq_s;
    logic                   core_lt_s;

    // Unpack the flat operand buses into per-requester views.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr_s[g] = a_in[g*WIDTH +: WIDTH];
        assign b_arr_s[g] = b_in[g*WIDTH +: WIDTH];
    end

    // Round-robin search: first set req bit at or above ptr_r, wrapping to 0.
    always_comb begin
        int idx_v;
        idx_v       = 0;
        win_found_s = 1'b0;
        win_id_s    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_v = int'(ptr_r) + k;
            if (idx_v >= NREQ) begin
                idx_v = idx_v - NREQ;
            end else begin
                idx_v = idx_v;
            end
            if (!win_found_s && req[IDW'(idx_v)]) begin
                win_found_s = 1'b1;
                win_id_s    = IDW'(idx_v);
            end else begin
                win_found_s = win_found_s;
                win_id_s    = win_id_s;
            end
        end
    end

    // One-hot decode of the winner for the grant output.
    always_comb begin
        grant_vec_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_vec_s[i] = (win_id_s == IDW'(i));
        end
    end

    // Shared comparator sees only the captured operands.
    comp_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a  (a_r),
        .b  (b_r),
        .gt (core_gt_s),
        .eq (core_eq_s),
        .lt (core_lt_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; req is only looked at in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    state_nxt_s = EVAL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EVAL: begin
                state_nxt_s = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM output decode: strobes that steer the registered datapath.
    always_comb begin
        grant_en_s = 1'b0;
        eval_en_s  = 1'b0;
        accept_s   = 1'b0;
        case (state_r)
            IDLE: begin
                grant_en_s = win_found_s;
            end
            EVAL: begin
                eval_en_s = 1'b1;
            end
            RESP: begin
                accept_s = rsp_ready;
            end
            default: begin
                grant_en_s = 1'b0;
            end
        endcase
    end

    // Grant edge: latch winner and its operands; the grant pulse spans EVAL.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_r <= '0;
            a_r  <= '0;
            b_r  <= '0;
            gnt  <= '0;
        end else if (grant_en_s) begin
            id_r <= win_id_s;
            a_r  <= a_arr_s[win_id_s];
            b_r  <= b_arr_s[win_id_s];
            gnt  <= grant_vec_s;
        end else if (eval_en_s) begin
            gnt  <= '0;
        end else begin
            gnt  <= gnt;
        end
    end

    // Response registers: loaded at the end of EVAL, held through back-pressure.
    // The flags are intentionally not cleared on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
        end else if (eval_en_s) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_r;
            gt        <= core_gt_s;
            eq        <= core_eq_s;
            lt        <= core_lt_s;
        end else if (accept_s) begin
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= rsp_valid;
        end
    end

    // Round-robin pointer moves past the served requester on accept only.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (accept_s) begin
            if (id_r == IDW'(NREQ - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= id_r + IDW'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // busy mirrors the state the FSM is entering, so it is registered too.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_nxt_s != IDLE);
        end
    end

endmodule

// File: tb/tb_comp_share_arb.sv
// -----------------------------------------------------------------------------
// tb_comp_share_arb
// Self-checking bench: directed scenarios followed by randomized traffic, all
// compared every cycle against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_comp_share_arb;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req;
    logic [NREQ*WIDTH-1:0]   a_in;
    logic [NREQ*WIDTH-1:0]   b_in;
    logic [NREQ-1:0]         gnt;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [IDW-1:0]          rsp_id;
    logic                    gt;
    logic                    eq;
    logic                    lt;
    logic                    busy;

    always #5 clk = ~clk;

    comp_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .gt        (gt),
        .eq        (eq),
        .lt        (lt),
        .busy      (busy)
    );

    comp_share_arb_chk #(.WIDTH(WIDTH), .NREQ(NREQ)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .gt        (gt),
        .eq        (eq),
        .lt        (lt),
        .busy      (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Operand values each requester currently presents.
    int a_v [NREQ];
    int b_v [NREQ];

    // Reference model: one pending transaction at a time.
    // m_phase: 0 = waiting for requests, 1 = winner granted, 2 = result offered.
    int              m_phase;
    int              m_ptr;
    int              m_win;
    int              m_a;
    int              m_b;
    logic [NREQ-1:0] m_gnt;
    logic            m_valid;
    int              m_rsp_id;
    logic            m_gt;
    logic            m_eq;
    logic            m_lt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model across one rising edge with the inputs applied to it.
    task automatic model_step(input logic [NREQ-1:0] r, input logic rdy, input logic rs);
        int  w;
        bit  found;
        if (rs) begin
            m_phase  = 0;
            m_ptr    = 0;
            m_gnt    = '0;
            m_valid  = 1'b0;
            m_rsp_id = 0;
            m_gt     = 1'b0;
            m_eq     = 1'b0;
            m_lt     = 1'b0;
        end else if (m_phase == 0) begin
            found = 1'b0;
            w     = 0;
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (!found && (((int'(r) >> c) & 1) == 1)) begin
                    found = 1'b1;
                    w     = c;
                end
            end
            if (found) begin
                m_win   = w;
                m_a     = a_v[w];
                m_b     = b_v[w];
                m_gnt   = NREQ'(32'd1 << w);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_gt     = (m_a > m_b);
            m_eq     = (m_a == m_b);
            m_lt     = (m_a < m_b);
            m_rsp_id = m_win;
            m_valid  = 1'b1;
            m_gnt    = '0;
            m_phase  = 2;
        end else begin
            if (rdy) begin
                m_valid = 1'b0;
                m_ptr   = (m_win + 1) % NREQ;
                m_phase = 0;
            end
        end
    endtask

    // Apply one cycle of stimulus, advance the model, compare after the edge.
    task automatic tick(input logic [NREQ-1:0] r, input logic rdy, input logic rs);
        req       = r;
        rsp_ready = rdy;
        rst       = rs;
        for (int i = 0; i < NREQ; i++) begin
            a_in[i*WIDTH +: WIDTH] = WIDTH'(a_v[i]);
            b_in[i*WIDTH +: WIDTH] = WIDTH'(b_v[i]);
        end
        @(posedge clk);
        model_step(r, rdy, rs);
        @(negedge clk);
        check_val("gnt",       32'(gnt),       32'(m_gnt));
        check_val("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        check_val("rsp_id",    32'(rsp_id),    32'(m_rsp_id));
        check_val("gt",        32'(gt),        32'(m_gt));
        check_val("eq",        32'(eq),        32'(m_eq));
        check_val("lt",        32'(lt),        32'(m_lt));
        check_val("busy",      32'(busy),      32'(m_phase != 0));
    endtask

    task automatic rand_operands();
        for (int i = 0; i < NREQ; i++) begin
            a_v[i] = int'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                b_v[i] = a_v[i];
            end else begin
                b_v[i] = int'($urandom_range(0, 15));
            end
        end
    endtask

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            a_v[i] = 0;
            b_v[i] = 0;
        end
        m_phase = 0; m_ptr = 0; m_win = 0; m_a = 0; m_b = 0;
        m_gnt = '0; m_valid = 1'b0; m_rsp_id = 0;
        m_gt = 1'b0; m_eq = 1'b0; m_lt = 1'b0;

        // Reset state.
        tick(4'b0000, 1'b1, 1'b1);
        tick(4'b0000, 1'b1, 1'b1);

        // Single requester, equal operands.
        a_v[0] = 12; b_v[0] = 12;
        tick(4'b0001, 1'b1, 1'b0);
        repeat (3) tick(4'b0000, 1'b1, 1'b0);

        // Less-than from requester 2, greater-than from requester 3.
        a_v[2] = 4;  b_v[2] = 12;
        tick(4'b0100, 1'b1, 1'b0);
        repeat (3) tick(4'b0000, 1'b1, 1'b0);
        a_v[3] = 15; b_v[3] = 12;
        tick(4'b1000, 1'b1, 1'b0);
        repeat (3) tick(4'b0000, 1'b1, 1'b0);

        // Pointer wrap after serving 3: requester 0 wins over 3; zero operands.
        a_v[0] = 0; b_v[0] = 0;
        a_v[3] = 0; b_v[3] = 15;
        tick(4'b1001, 1'b1, 1'b0);
        repeat (4) tick(4'b1000, 1'b1, 1'b0);
        repeat (3) tick(4'b0000, 1'b1, 1'b0);

        // Fairness with all requesters held active.
        a_v[0] = 1; b_v[0] = 2;
        a_v[1] = 9; b_v[1] = 3;
        a_v[2] = 7; b_v[2] = 7;
        a_v[3] = 15; b_v[3] = 0;
        repeat (16) tick(4'b1111, 1'b1, 1'b0);
        repeat (3) tick(4'b0000, 1'b1, 1'b0);

        // Back-pressure with inputs churning during RESP.
        a_v[1] = 5; b_v[1] = 10;
        tick(4'b0010, 1'b1, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            rand_operands();
            tick(4'(i + 9), 1'b0, 1'b0);
        end
        tick(4'b1101, 1'b1, 1'b0);
        repeat (4) tick(4'b1101, 1'b1, 1'b0);
        repeat (4) tick(4'b0000, 1'b1, 1'b0);

        // Reset in EVAL, then reset in RESP; pointer restarts at 0.
        tick(4'b1000, 1'b1, 1'b0);
        tick(4'b0000, 1'b1, 1'b1);
        a_v[2] = 3; b_v[2] = 11;
        tick(4'b0100, 1'b1, 1'b0);
        tick(4'b0000, 1'b1, 1'b0);
        tick(4'b0000, 1'b0, 1'b1);
        tick(4'b0100, 1'b1, 1'b0);
        repeat (3) tick(4'b0000, 1'b1, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            rand_operands();
            tick(4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 63) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
